// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. Owns the program counter, presents it to a
// combinational instruction memory, and captures each returned word together
// with its fetch address into an IF/ID output register. Downstream flow control
// is a valid/ready handshake. A taken branch/jump redirects and flushes. Fetch
// stops on a HALT instruction.
//
// Handshake: the IF/ID register offers a transfer whenever out_valid is high.
// A transfer completes on a rising edge where out_valid and out_ready are both
// high. While out_valid is high and out_ready is low, out_instr and out_pc hold
// steady. out_valid never drops without a completed transfer, except on a
// redirect flush or a reset.
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   imem_addr       out  instruction memory read address (equals the PC)
//   imem_data       in   instruction word for imem_addr, same cycle
//   out_valid       out  IF/ID register holds a valid instruction
//   out_ready       in   decode accepts the IF/ID contents this cycle
//   out_instr       out  fetched instruction
//   out_pc          out  address the instruction was fetched from
//   redirect_valid  in   branch/jump taken: flush and restart fetch
//   redirect_pc     in   new fetch address
//   halted          out  high while in the HALT state (this is the FSM state)
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter int unsigned          ADDR_W    = 8,
   parameter int unsigned          DATA_W    = 32,
   parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
   parameter logic [DATA_W-1:0]    HALT_WORD = '1
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0]        state_q,  state_d;
   logic [ADDR_W-1:0] pc_q,     pc_d;
   logic              valid_q,  valid_d;
   logic [DATA_W-1:0] instr_q,  instr_d;
   logic [ADDR_W-1:0] opc_q,    opc_d;

   logic              load;
   logic              is_halt_word;

   // A new word may enter the IF/ID register when it is empty or being drained
   // on this same edge, which is what gives one instruction per cycle.
   assign load         = (state_q == ST_RUN) && !redirect_valid && (!valid_q || out_ready);
   assign is_halt_word = (imem_data == HALT_WORD);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      if (redirect_valid) begin
         // Flush wins over everything else, including a pending acceptance.
         pc_d    = redirect_pc;
         valid_d = 1'b0;
         state_d = ST_RUN;
      end else if (load) begin
         instr_d = imem_data;
         opc_d   = pc_q;
         valid_d = 1'b1;
         if (is_halt_word) begin
            // The HALT word is still emitted; the PC parks on its address.
            state_d = ST_HALT;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= '0;
         opc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = valid_q;
   assign out_instr = instr_q;
   assign out_pc    = opc_q;
   assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Bench for inst_fetch. Memory model: mem[a] = {24'hA5A5A5, a}, except
// mem[8'h2C] = HALT word. Directed scenario tasks followed by a randomized run
// checked against an expected-stream model: after a redirect to X, decode must
// receive X, X+1, ... (mod 256) in order, ending after the HALT address.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

   localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
   localparam logic [7:0]  HALT_A = 8'h2C;

   logic        clk;
   logic        rst;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        halted;

   int checks;
   int failures;

   inst_fetch #(
      .ADDR_W    (8),
      .DATA_W    (32),
      .RESET_PC  (8'h00),
      .HALT_WORD (HALT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [7:0] a);
      if (a == HALT_A) return HALT_W;
      return {24'hA5A5A5, a};
   endfunction

   assign imem_data = mem_model(imem_addr);

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 8'h00 ||
          halted !== 1'b0 || imem_addr !== 8'h00) begin
         failures++;
         $display("FAIL reset: valid=%0b instr=%h pc=%h halted=%0b addr=%h want 0/0/0/0/0",
                  out_valid, out_instr, out_pc, halted, imem_addr);
      end
   endtask

   task automatic test_streaming();
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 8'(i) || out_instr !== {24'hA5A5A5, 8'(i)} ||
             imem_addr !== 8'(i + 1)) begin
            failures++;
            $display("FAIL stream[%0d]: valid=%0b pc=%h instr=%h addr=%h want 1/%h/%h/%h",
                     i, out_valid, out_pc, out_instr, imem_addr, 8'(i), {24'hA5A5A5, 8'(i)}, 8'(i + 1));
         end
      end
   endtask

   task automatic test_back_pressure();
      // pc 05 is pending from the streaming run
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 8'h05 || out_instr !== 32'hA5A5A505 ||
             imem_addr !== 8'h06) begin
            failures++;
            $display("FAIL backpressure[%0d]: valid=%0b pc=%h instr=%h addr=%h want 1/05/a5a5a505/06",
                     i, out_valid, out_pc, out_instr, imem_addr);
         end
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'h06 || out_instr !== 32'hA5A5A506) begin
         failures++;
         $display("FAIL backpressure_release: valid=%0b pc=%h instr=%h want 1/06/a5a5a506",
                  out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_redirect();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();   // 06 -> 10
      checks++;
      if (out_pc !== 8'h10 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL redirect_setup: pc=%h valid=%0b want 10/1", out_pc, out_valid);
      end
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h33;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || imem_addr !== 8'h33) begin
         failures++;
         $display("FAIL redirect_flush: valid=%0b addr=%h want 0/33", out_valid, imem_addr);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'h33 || out_instr !== 32'hA5A5A533) begin
         failures++;
         $display("FAIL redirect_target: valid=%0b pc=%h instr=%h want 1/33/a5a5a533",
                  out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_pc;
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hFE;
      step();
      redirect_valid = 1'b0;
      exp_pc = 8'hFE;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem_model(exp_pc)) begin
            failures++;
            $display("FAIL wrap[%0d]: valid=%0b pc=%h instr=%h want 1/%h/%h",
                     i, out_valid, out_pc, out_instr, exp_pc, mem_model(exp_pc));
         end
         exp_pc = exp_pc + 8'd1;
      end
   endtask

   task automatic test_halt();
      logic [7:0] exp_pc;
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h2A;
      step();
      redirect_valid = 1'b0;
      exp_pc = 8'h2A;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem_model(exp_pc) ||
             halted !== (exp_pc == HALT_A)) begin
            failures++;
            $display("FAIL halt_seq[%0d]: valid=%0b pc=%h instr=%h halted=%0b want 1/%h/%h/%0b",
                     i, out_valid, out_pc, out_instr, halted, exp_pc, mem_model(exp_pc),
                     exp_pc == HALT_A);
         end
         exp_pc = exp_pc + 8'd1;
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== HALT_A) begin
            failures++;
            $display("FAIL halt_idle[%0d]: valid=%0b halted=%0b addr=%h want 0/1/2c",
                     i, out_valid, halted, imem_addr);
         end
      end
      redirect_valid = 1'b1; redirect_pc = 8'h00;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 8'h00) begin
         failures++;
         $display("FAIL halt_exit: halted=%0b valid=%0b addr=%h want 0/0/00", halted, out_valid, imem_addr);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 32'hA5A5A500) begin
         failures++;
         $display("FAIL halt_resume: valid=%0b pc=%h instr=%h want 1/00/a5a5a500",
                  out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h55;
      step();
      rst = 1'b0; redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 8'h00 ||
          halted !== 1'b0 || imem_addr !== 8'h00) begin
         failures++;
         $display("FAIL reset_mid: valid=%0b instr=%h pc=%h halted=%0b addr=%h want 0/0/0/0/00",
                  out_valid, out_instr, out_pc, halted, imem_addr);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 32'hA5A5A500) begin
         failures++;
         $display("FAIL reset_mid_restart: valid=%0b pc=%h instr=%h want 1/00/a5a5a500",
                  out_valid, out_pc, out_instr);
      end
   endtask

   // Random ready/redirect traffic. Expected model: the ordered address stream
   // decode should receive, restarted by each redirect and closed after HALT.
   task automatic test_random();
      logic [7:0]  exp_next;
      logic        exp_done;
      logic        rdy, redir;
      logic [7:0]  tgt;
      logic        pre_valid;
      logic [7:0]  pre_pc;
      logic [31:0] pre_instr;
      int          accepts;
      exp_next = 8'h00; exp_done = 1'b0; accepts = 0;
      for (int c = 0; c < 600; c++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         redir = (c == 0) || ($urandom_range(0, 11) == 0);
         tgt   = ($urandom_range(0, 2) == 0) ? 8'(8'h26 + $urandom_range(0, 6)) : 8'($urandom_range(0, 255));
         out_ready = rdy; redirect_valid = redir; redirect_pc = tgt;
         pre_valid = out_valid; pre_pc = out_pc; pre_instr = out_instr;
         step();
         if (redir) begin
            exp_next = tgt; exp_done = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== tgt) begin
               failures++;
               $display("FAIL rnd_redirect[%0d]: valid=%0b halted=%0b addr=%h want 0/0/%h",
                        c, out_valid, halted, imem_addr, tgt);
            end
         end else if (pre_valid && rdy) begin
            accepts++;
            checks++;
            if (exp_done || pre_pc !== exp_next || pre_instr !== mem_model(exp_next)) begin
               failures++;
               $display("FAIL rnd_accept[%0d]: pc=%h instr=%h want pc=%h instr=%h stream_closed=%0b",
                        c, pre_pc, pre_instr, exp_next, mem_model(exp_next), exp_done);
            end
            if (exp_next == HALT_A) exp_done = 1'b1;
            else exp_next = exp_next + 8'd1;
         end else if (pre_valid) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pre_pc || out_instr !== pre_instr) begin
               failures++;
               $display("FAIL rnd_hold[%0d]: valid=%0b pc=%h instr=%h want 1/%h/%h",
                        c, out_valid, out_pc, out_instr, pre_pc, pre_instr);
            end
         end
         if (exp_done && !redir) begin
            checks++;
            if (halted !== 1'b1 || out_valid !== 1'b0) begin
               failures++;
               $display("FAIL rnd_halted[%0d]: halted=%0b valid=%0b want 1/0", c, halted, out_valid);
            end
         end
      end
      redirect_valid = 1'b0;
      checks++;
      if (accepts < 100) begin
         failures++;
         $display("FAIL rnd_progress: accepts=%0d want >=100", accepts);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
      test_reset();
      test_streaming();
      test_back_pressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
